// File: rtl/obj_buffer_ring.sv
// obj_buffer_ring
//   First-word-fall-through ring of serializer entries plus a stack of object
//   base addresses. The ring holds {field_id, nested, wire type, offset}
//   entries. When an entry leaves the head, the stack tracks which C++ object
//   owns the next entry:
//     - a nested entry opens a child object at parent_base + offset;
//     - a field_id 0 entry closes the current child object.
//   A field_id 0 entry seen at depth 0 is the terminal marker. It is never
//   offered to the serializer; it retires by itself and pulses done.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   base_load, base_addr_in     load the root base address (only when idle)
//   in_valid/in_ready/in_*      producer side (field_id, nested, type, offset)
//   out_valid/out_ready/out_*   serializer side, head entry fields
//   out_end                     head is a non-terminal end marker
//   out_base_addr               base address of the object owning the head
//   depth, count                nesting depth, ring occupancy
//   done                        terminal marker retires this cycle
//   err_overflow, err_load      sticky errors, cleared only by reset
module obj_buffer_ring #(
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       STACK_DEPTH = 16,
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       FIELD_W     = 8,
  parameter int unsigned       OFFSET_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_BASE  = 'h100
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               base_load,
  input  logic [ADDR_W-1:0]                  base_addr_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [FIELD_W-1:0]                 in_field_id,
  input  logic                               in_nested,
  input  logic [2:0]                         in_type,
  input  logic [OFFSET_W-1:0]                in_offset,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FIELD_W-1:0]                 out_field_id,
  output logic                               out_nested,
  output logic [2:0]                         out_type,
  output logic [OFFSET_W-1:0]                out_offset,
  output logic                               out_end,
  output logic [ADDR_W-1:0]                  out_base_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               done,
  output logic                               err_overflow,
  output logic                               err_load
);

  localparam int unsigned RAW = $clog2(DEPTH);          // ring index width
  localparam int unsigned PW  = RAW + 1;                // pointer width with wrap bit
  localparam int unsigned CW  = $clog2(DEPTH + 1);      // count width
  localparam int unsigned SAW = $clog2(STACK_DEPTH);    // stack index width
  localparam int unsigned DW  = $clog2(STACK_DEPTH + 1);

  typedef struct packed {
    logic [FIELD_W-1:0]  field_id;
    logic                nested;
    logic [2:0]          wtype;
    logic [OFFSET_W-1:0] offset;
  } entry_t;

  entry_t              ring_mem [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  // The root base lives in its own register so it can be reset on its own.
  // Slot 0 of stack_mem is therefore never used.
  logic [ADDR_W-1:0]   base_root;
  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

  entry_t              head_entry;
  logic                non_empty;
  logic                head_marker;
  logic                terminal;
  logic                push;
  logic                pop;
  logic                idle;
  logic                at_top;
  logic                open_child;
  logic [SAW-1:0]      child_slot;
  logic [ADDR_W-1:0]   child_base;

  // The wrap bit lets a full ring (count == DEPTH) be told apart from an
  // empty one.
  assign count       = CW'(tail - head);
  assign non_empty   = (count != '0);
  assign in_ready    = (count != CW'(DEPTH));
  assign head_entry  = ring_mem[head[RAW-1:0]];
  assign head_marker = (head_entry.field_id == '0);

  // The terminal marker is hidden from the serializer and retires on the next
  // edge. done marks the cycle it sits at the head.
  assign terminal  = non_empty && head_marker && (depth == '0);
  assign out_valid = non_empty && !terminal;
  assign out_end   = non_empty && head_marker && (depth != '0);
  assign done      = terminal;

  assign out_field_id = head_entry.field_id;
  assign out_nested   = head_entry.nested;
  assign out_type     = head_entry.wtype;
  assign out_offset   = head_entry.offset;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign idle   = !non_empty && (depth == '0);
  assign at_top = (depth == DW'(STACK_DEPTH - 1));

  assign out_base_addr = (depth == '0) ? base_root : stack_mem[depth[SAW-1:0]];
  assign child_slot    = depth[SAW-1:0] + SAW'(1);
  assign child_base    = out_base_addr + ADDR_W'(head_entry.offset);
  // An end marker pops the stack even if its nested bit is set.
  // A nested entry at the top of the stack only raises err_overflow.
  assign open_child    = pop && !head_marker && head_entry.nested && !at_top;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      depth        <= '0;
      base_root    <= RESET_BASE;
      err_overflow <= 1'b0;
      err_load     <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop || terminal) head <= head + PW'(1);

      // A popped marker always has depth > 0 (terminal markers never pop).
      if (pop && head_marker) begin
        depth <= depth - DW'(1);
      end else if (pop && head_entry.nested) begin
        if (at_top) err_overflow <= 1'b1;
        else        depth        <= depth + DW'(1);
      end

      if (base_load) begin
        if (idle) base_root <= base_addr_in;
        else      err_load  <= 1'b1;
      end
    end
  end

  // NOTE: ring and stack contents carry no reset. count and depth gate every
  // read, so a slot is always written before it is used, and these arrays can
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      ring_mem[tail[RAW-1:0]] <= '{field_id: in_field_id, nested: in_nested,
                                   wtype: in_type, offset: in_offset};
    end
    if (open_child) stack_mem[child_slot] <= child_base;
  end

endmodule

// File: tb/tb_obj_buffer_ring.sv
// tb_obj_buffer_ring
//   Bench for obj_buffer_ring, built with DEPTH=4 and STACK_DEPTH=2 so the
//   full/wrap and overflow cases are reachable. Each entry record carries the
//   base, depth and end flag it must show at the head. An accepted record goes
//   onto a queue, and the negedge monitor pops and compares a record every
//   time the serializer takes an entry.
module tb_obj_buffer_ring;

  localparam int DEPTH       = 4;
  localparam int STACK_DEPTH = 2;
  localparam int ADDR_W      = 64;
  localparam int FIELD_W     = 8;
  localparam int OFFSET_W    = 32;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int DW          = $clog2(STACK_DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                base_load;
  logic [ADDR_W-1:0]   base_addr_in;
  logic                in_valid;
  logic                in_ready;
  logic [FIELD_W-1:0]  in_field_id;
  logic                in_nested;
  logic [2:0]          in_type;
  logic [OFFSET_W-1:0] in_offset;
  logic                out_valid;
  logic                out_ready;
  logic [FIELD_W-1:0]  out_field_id;
  logic                out_nested;
  logic [2:0]          out_type;
  logic [OFFSET_W-1:0] out_offset;
  logic                out_end;
  logic [ADDR_W-1:0]   out_base_addr;
  logic [DW-1:0]       depth;
  logic [CW-1:0]       count;
  logic                done;
  logic                err_overflow;
  logic                err_load;

  always #5 clk = ~clk;

  obj_buffer_ring #(
    .DEPTH(DEPTH), .STACK_DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W),
    .FIELD_W(FIELD_W), .OFFSET_W(OFFSET_W), .RESET_BASE('h100)
  ) dut (
    .clk(clk), .reset(reset), .base_load(base_load), .base_addr_in(base_addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_field_id(in_field_id),
    .in_nested(in_nested), .in_type(in_type), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_field_id(out_field_id),
    .out_nested(out_nested), .out_type(out_type), .out_offset(out_offset),
    .out_end(out_end), .out_base_addr(out_base_addr), .depth(depth),
    .count(count), .done(done), .err_overflow(err_overflow), .err_load(err_load)
  );

  typedef struct {
    logic [FIELD_W-1:0]  fid;
    logic                nested;
    logic [2:0]          wtype;
    logic [OFFSET_W-1:0] offset;
    logic                expect_out;   // 0 for terminal markers
    logic [ADDR_W-1:0]   exp_base;
    logic                exp_end;
    logic [DW-1:0]       exp_depth;
  } vec_t;

  vec_t vecs [20];
  vec_t exp_q [$];
  vec_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   d0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [FIELD_W-1:0] fid, input logic nested,
                              input logic [2:0] wt, input logic [OFFSET_W-1:0] off,
                              input logic eo, input logic [ADDR_W-1:0] base,
                              input logic eend, input logic [DW-1:0] d);
    vec_t v;
    v.fid = fid; v.nested = nested; v.wtype = wt; v.offset = off;
    v.expect_out = eo; v.exp_base = base; v.exp_end = eend; v.exp_depth = d;
    return v;
  endfunction

  // Scoreboard monitor: compare each entry the serializer accepts.
  always @(negedge clk) begin
    if (reset) begin
      if (done) n_done++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got field %0h, required no output", out_field_id);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_entry", {out_field_id, out_nested, out_type, out_offset},
                {mon_e.fid, mon_e.nested, mon_e.wtype, mon_e.offset});
          check("out_base", out_base_addr, mon_e.exp_base);
          check("out_end_depth", {out_end, depth}, {mon_e.exp_end, mon_e.exp_depth});
        end
      end
    end
  end

  // Called at posedge+1. Holds the entry until it is accepted or times out.
  task automatic push_entry(input vec_t v);
    int waited = 0;
    bit acc = 1'b0;
    in_valid = 1'b1; in_field_id = v.fid; in_nested = v.nested;
    in_type = v.wtype; in_offset = v.offset;
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        if (v.expect_out) exp_q.push_back(v);
      end
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    check("push_accepted", acc, 1'b1);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_entry(vecs[i]);
  endtask

  task automatic wait_count_zero(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count != '0 && n < budget);
    check({tag, "_drain_count"}, count, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // fid nested type offset | expect_out base end depth
    vecs[0]  = mk(8'd3, 0, 3'd0, 32'h0,  1, 'h100, 0, 0);  // flat
    vecs[1]  = mk(8'd5, 0, 3'd5, 32'h4,  1, 'h100, 0, 0);
    vecs[2]  = mk(8'd0, 0, 3'd0, 32'h0,  0, 'h100, 0, 0);
    vecs[3]  = mk(8'd1, 1, 3'd2, 32'h20, 1, 'h100, 0, 0);  // nested
    vecs[4]  = mk(8'd7, 0, 3'd0, 32'h4,  1, 'h120, 0, 1);
    vecs[5]  = mk(8'd0, 0, 3'd0, 32'h0,  1, 'h120, 1, 1);
    vecs[6]  = mk(8'd2, 0, 3'd1, 32'h8,  1, 'h100, 0, 0);
    vecs[7]  = mk(8'd0, 0, 3'd0, 32'h0,  0, 'h100, 0, 0);
    vecs[8]  = mk(8'd1, 1, 3'd2, 32'h40, 1, 'h100, 0, 0);  // backpressure
    vecs[9]  = mk(8'd9, 0, 3'd1, 32'hc,  1, 'h140, 0, 1);
    vecs[10] = mk(8'd1, 1, 3'd2, 32'h10, 1, 'h100, 0, 0);  // overflow
    vecs[11] = mk(8'd2, 1, 3'd2, 32'h30, 1, 'h110, 0, 1);
    vecs[12] = mk(8'd8, 0, 3'd0, 32'h0,  1, 'h110, 0, 1);
    vecs[13] = mk(8'd0, 0, 3'd0, 32'h0,  1, 'h110, 1, 1);
    vecs[14] = mk(8'd1, 1, 3'd2, 32'h60, 1, 'h100, 0, 0);  // mid-op reset
    vecs[15] = mk(8'd4, 0, 3'd0, 32'h0,  1, 'h160, 0, 1);
    vecs[16] = mk(8'd5, 0, 3'd0, 32'h4,  1, 'h160, 0, 1);
    vecs[17] = mk(8'd6, 0, 3'd0, 32'h8,  1, 'h160, 0, 1);
    vecs[18] = mk(8'd3, 0, 3'd0, 32'h0,  1, 'h5000, 0, 0); // after base_load
    vecs[19] = mk(8'd0, 0, 3'd0, 32'h0,  0, 'h5000, 0, 0);

    reset = 1'b1; base_load = 1'b0; base_addr_in = '0; in_valid = 1'b0;
    in_field_id = '0; in_nested = 1'b0; in_type = '0; in_offset = '0; out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_depth", depth, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_overflow, err_load}, 0);
    check("rst_base", out_base_addr, 'h100);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Flat object
    out_ready = 1'b1;
    d0 = n_done;
    apply_vecs(0, 2);
    wait_count_zero("flat", 40);
    repeat (2) @(posedge clk);
    #1;
    check("flat_done_pulses", n_done - d0, 1);
    check("flat_sb_empty", exp_q.size(), 0);

    // Nested object
    do_reset();
    out_ready = 1'b1;
    d0 = n_done;
    apply_vecs(3, 7);
    wait_count_zero("nest", 40);
    repeat (2) @(posedge clk);
    #1;
    check("nest_done_pulses", n_done - d0, 1);
    check("nest_depth", depth, 0);
    check("nest_sb_empty", exp_q.size(), 0);

    // Full and wrap
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_entry(mk(8'(10 + k), 0, 3'd0, 32'(k * 4), 1, 'h100, 0, 0));
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    @(posedge clk); #1;
    in_valid = 1'b1; in_field_id = 8'd99; in_nested = 1'b0; in_offset = '0;
    @(negedge clk);
    check("full_blocks_push", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_still_4", count, 4);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_field_id = 8'(14 + k); in_nested = 1'b0;
      in_type = 3'(k); in_offset = 32'(k * 8);
      @(negedge clk);
      check("wrap_in_ready", in_ready, 1);
      check("wrap_count", count, 3);
      if (in_ready) exp_q.push_back(mk(8'(14 + k), 0, 3'(k), 32'(k * 8), 1, 'h100, 0, 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_count_zero("wrap", 40);
    check("wrap_sb_empty", exp_q.size(), 0);

    // Backpressure: two entries held for five cycles
    do_reset();
    out_ready = 1'b0;
    apply_vecs(8, 9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_head", {out_field_id, out_nested, out_offset}, {8'd1, 1'b1, 32'h40});
      check("bp_base", out_base_addr, 'h100);
      check("bp_count_depth", {count, depth}, {3'd2, 2'd0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_count_zero("bp", 40);
    check("bp_sb_empty", exp_q.size(), 0);
    // count is 0, but depth is 1, so the block is not idle.
    base_load = 1'b1; base_addr_in = 'hbeef;
    @(posedge clk); #1;
    base_load = 1'b0;
    check("bp_err_load", err_load, 1);
    check("bp_base_kept", out_base_addr, 'h140);

    // Stack overflow, then base_load while busy
    do_reset();
    out_ready = 1'b1;
    apply_vecs(10, 11);
    wait_count_zero("ovf", 40);
    check("ovf_flag", err_overflow, 1);
    check("ovf_depth", depth, 1);
    check("ovf_base", out_base_addr, 'h110);
    out_ready = 1'b0;
    apply_vecs(12, 12);
    base_load = 1'b1; base_addr_in = 'hdead;
    @(posedge clk); #1;
    base_load = 1'b0;
    check("ovf_err_load", err_load, 1);
    apply_vecs(13, 13);
    out_ready = 1'b1;
    wait_count_zero("ovf2", 40);
    check("ovf_root_kept", out_base_addr, 'h100);
    check("ovf_depth_back", depth, 0);
    check("ovf_sticky", {err_overflow, err_load}, 2'b11);
    check("ovf_sb_empty", exp_q.size(), 0);

    // Reset in the middle of an operation
    do_reset();
    out_ready = 1'b1;
    apply_vecs(14, 14);
    wait_count_zero("mid", 40);
    out_ready = 1'b0;
    apply_vecs(15, 17);
    @(negedge clk);
    check("mid_queued", {count, depth}, {3'd3, 2'd1});
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("mid_rst_count", count, 0);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_base", out_base_addr, 'h100);
    check("mid_rst_flags", {out_valid, in_ready, done}, 3'b010);
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // base_load while idle takes effect on the next edge
    base_load = 1'b1; base_addr_in = 'h5000;
    @(negedge clk);
    check("load_not_yet", out_base_addr, 'h100);
    @(posedge clk); #1;
    base_load = 1'b0;
    check("load_applied", out_base_addr, 'h5000);
    check("load_no_err", err_load, 0);
    out_ready = 1'b1;
    d0 = n_done;
    apply_vecs(18, 19);
    wait_count_zero("load", 40);
    repeat (2) @(posedge clk);
    #1;
    check("load_done_pulses", n_done - d0, 1);
    check("load_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
